axis_packet_source: RTL and testbench
=====================================

Name: axis_packet_source

Overview:
- AXI-Stream master that generates test packets for the slave port of axis_multiplexer, at the head of the mux -> ensemble -> majority-vote datapath.
- Replaces hand-driven stimulus with a configurable, protocol-compliant transmitter.
- Supports run-time packet length, data pattern, backpressure, and clean early termination.

Parameters:
DATA_WIDTH, 32, width of m_axis_tdata and seed
LEN_WIDTH, 16, width of pkt_len and internal word counter
CNT_WIDTH, 16, width of pkts_sent counter

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-high (asserted when 1)
start  in  1  single-cycle request to send one packet; honoured only in IDLE
pkt_len  in  LEN_WIDTH  number of words in packet; latched on accepted start
mode  in  2  pattern: 0 constant, 1 incrementing, 2 alternating, 3 reserved (acts as 0); latched on start
seed  in  DATA_WIDTH  first data word; latched on start
abort  in  1  request early termination of current packet
m_axis_tdata  out  DATA_WIDTH  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last word of packet
busy  out  1  high in SEND and DONE
done  out  1  one-cycle pulse when packet finished
pkts_sent  out  CNT_WIDTH  count of completed non-empty packets

Behaviour:
- Reset (rst_n=1, asynchronous) sets: state IDLE; m_axis_tvalid=0; m_axis_tlast=0; m_axis_tdata=0; busy=0; done=0; pkts_sent=0; abort flag cleared. Reset mid-packet drops tvalid immediately; the partial packet is not counted.
- All outputs are registered.
- Handshake: a word transfers on a rising edge with tvalid=1 and tready=1.
- While tvalid=1 and tready=0, tdata, tvalid and tlast are held stable.
- tvalid never deasserts before its handshake.
- FSM IDLE -> SEND -> DONE -> IDLE.
- IDLE:
  - start=1 with pkt_len>=1 latches pkt_len, mode and seed, then enters SEND.
  - On the next edge, tvalid=1 and tdata=seed. Latency is 1 cycle from start to first tvalid.
  - tlast=1 on the first word if pkt_len=1.
- IDLE, pkt_len=0: start=1 goes directly to DONE. No transfer occurs and pkts_sent is unchanged.
- SEND, on each handshake:
  - word index k increments.
  - Next tdata: mode0 = seed; mode1 = seed+k (mod 2^DATA_WIDTH, wrap silently); mode2 = seed for even k, ~seed for odd k.
  - tlast=1 exactly when k = latched_len-1.
- SEND, handshake with tlast=1: go to DONE and deassert tvalid/tlast on that edge. There is no bubble-free back-to-back packet.
- abort:
  - Sampled every cycle in SEND and held in a sticky flag.
  - The next presented word that has not yet handshaken is not modified.
  - The first word presented after the flag is set carries tlast=1, which truncates the packet.
  - If abort arrives in the same cycle as a handshake, that handshake's next word (if any) is the final word with tlast=1.
  - If abort arrives in the same cycle as the natural last handshake, it has no effect.
  - The flag is cleared on entering DONE.
  - An aborted packet counts in pkts_sent.
  - abort is ignored in IDLE and DONE.
- DONE: done=1 for exactly one cycle; pkts_sent increments by 1 (wraps at 2^CNT_WIDTH) for a non-empty packet; then IDLE.
- start in SEND or DONE is ignored and not queued.
- Inputs pkt_len, mode and seed may change freely after start; only the latched values are used.
- busy=1 in SEND and DONE, 0 in IDLE. The earliest next start is accepted in the cycle busy=0.

Test Plan:
- Single word: mode0, seed=FFFFFFFF, pkt_len=1, tready=1, start at cycle N -> cycle N+1 tvalid=1, tlast=1, tdata=FFFFFFFF; handshake; done at N+2; pkts_sent=1.
- Incrementing with backpressure: mode1, seed=FFFFFFFE, pkt_len=4, tready toggled 1,0,0,1,... -> words FFFFFFFE, FFFFFFFF, 00000000, 00000001; each word stable while tready=0; tlast only on 00000001.
- Alternating pattern: mode2, seed=A5A5A5A5, pkt_len=3 -> A5A5A5A5, 5A5A5A5A, A5A5A5A5 (tlast); start pulsed mid-packet is ignored; pkts_sent increments by 1.
- Abort: pkt_len=10, mode1, seed=0, tready=1, abort pulsed in the cycle word 2 handshakes -> word 3 (value 3) has tlast=1; 4 words total; done pulse; pkts_sent increments.
- Zero length and reset: start with pkt_len=0 -> no tvalid, done pulse 1 cycle later, pkts_sent unchanged. Then start pkt_len=5, assert rst_n=1 after 2 words -> tvalid=0 immediately, pkts_sent=0, busy=0.

Source files
------------

// File: rtl/axis_packet_source_if.sv
// rtl/axis_packet_source_if.sv - AXI-Stream style handshake bundle for the packet source
interface axis_packet_source_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_packet_source.sv
// rtl/axis_packet_source.sv - configurable test packet transmitter with backpressure and abort
// Patterns: constant, incrementing, alternating seed/~seed; abort truncates after the presented word.
module axis_packet_source #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  abort,
  axis_packet_source_if.master  m_axis,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  pkts_sent
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  idx;
  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic                  abort_q;
  logic [LEN_WIDTH-1:0]  idx_next;
  logic                  last_next;

  function automatic logic [DATA_WIDTH-1:0] word_at(input logic [1:0] md,
                                                    input logic [DATA_WIDTH-1:0] sd,
                                                    input logic [LEN_WIDTH-1:0] k);
    case (md)
      2'd1:    return sd + DATA_WIDTH'(k);
      2'd2:    return k[0] ? ~sd : sd;
      default: return sd;
    endcase
  endfunction

  assign idx_next = idx + LEN_WIDTH'(1);
  // An abort seen now (or earlier) makes the word about to be presented the final one.
  assign last_next = (idx_next == len_q - LEN_WIDTH'(1)) || abort_q || abort;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state         <= IDLE;
      len_q         <= '0;
      idx           <= '0;
      mode_q        <= '0;
      seed_q        <= '0;
      abort_q       <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pkts_sent     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (pkt_len != '0) begin
              state         <= SEND;
              len_q         <= pkt_len;
              mode_q        <= mode;
              seed_q        <= seed;
              idx           <= '0;
              m_axis.tdata  <= seed;
              m_axis.tvalid <= 1'b1;
              m_axis.tlast  <= (pkt_len == LEN_WIDTH'(1));
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SEND: begin
          abort_q <= abort_q | abort;
          if (m_axis.tvalid && m_axis.tready) begin
            if (m_axis.tlast) begin
              state         <= DONE;
              m_axis.tvalid <= 1'b0;
              m_axis.tlast  <= 1'b0;
              done          <= 1'b1;
              pkts_sent     <= pkts_sent + CNT_WIDTH'(1);
              abort_q       <= 1'b0;
            end else begin
              idx          <= idx_next;
              m_axis.tdata <= word_at(mode_q, seed_q, idx_next);
              m_axis.tlast <= last_next;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_source.sv
// tb/tb_axis_packet_source.sv - self-checking bench for axis_packet_source
module tb_axis_packet_source;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] pkt_len = '0;
  logic [1:0]    mode = '0;
  logic [DW-1:0] seed = '0;
  logic          busy;
  logic          done;
  logic [CW-1:0] pkts_sent;

  int passed = 0;
  int total = 0;
  int exp_pkts = 0;

  axis_packet_source_if #(.DATA_WIDTH(DW)) m_axis();

  axis_packet_source #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .pkt_len(pkt_len),
    .mode(mode),
    .seed(seed),
    .abort(abort),
    .m_axis(m_axis),
    .busy(busy),
    .done(done),
    .pkts_sent(pkts_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] exp_word(input logic [1:0] md, input logic [DW-1:0] sd, input int i);
    if (md == 2'd1) return sd + DW'(i);
    if (md == 2'd2) return (i % 2 == 1) ? ~sd : sd;
    return sd;
  endfunction

  // rdy_mode: 0 always ready, 1 random, 2 repeating 1,0,0,1. abort_at: word index being presented when abort pulses.
  task automatic run_packet(input int len, input logic [1:0] md, input logic [DW-1:0] sd,
                            input int rdy_mode, input int abort_at, input bit mid_start);
    logic [DW-1:0] words[$];
    int  exp_n;
    int  n;
    int  c;
    bit  hs;
    bit  aborted;
    exp_n = (abort_at >= 0 && abort_at + 2 < len) ? abort_at + 2 : len;
    for (int i = 0; i < exp_n; i++) words.push_back(exp_word(md, sd, i));
    start = 1'b1;
    pkt_len = LW'(len);
    mode = md;
    seed = sd;
    step();
    start = 1'b0;
    pkt_len = LW'($urandom);
    mode = 2'($urandom);
    seed = $urandom;
    if (len == 0) begin
      chk("zl_tvalid", m_axis.tvalid, 0);
      chk("zl_done", done, 1);
      chk("zl_busy", busy, 1);
      chk("zl_cnt", pkts_sent, exp_pkts);
      step();
      chk("zl_done_clr", done, 0);
      chk("zl_busy_clr", busy, 0);
      chk("zl_tvalid2", m_axis.tvalid, 0);
      return;
    end
    chk("busy_send", busy, 1);
    n = 0;
    c = 0;
    aborted = 0;
    while (n < exp_n && c < 300) begin
      chk("tvalid", m_axis.tvalid, 1);
      chk("tdata", m_axis.tdata, words[n]);
      chk("tlast", m_axis.tlast, (n == exp_n - 1));
      chk("done_low", done, 0);
      chk("cnt_hold", pkts_sent, exp_pkts);
      case (rdy_mode)
        0:       m_axis.tready = 1'b1;
        1:       m_axis.tready = ($urandom_range(0, 3) != 0);
        default: m_axis.tready = (c % 4 == 0) || (c % 4 == 3);
      endcase
      if (!aborted && n == abort_at) begin
        abort = 1'b1;
        aborted = 1;
      end
      if (mid_start && c == 1) start = 1'b1;
      hs = m_axis.tvalid && m_axis.tready;
      step();
      abort = 1'b0;
      start = 1'b0;
      c++;
      if (hs) n++;
    end
    chk("word_count", n, exp_n);
    chk("end_tvalid", m_axis.tvalid, 0);
    chk("end_tlast", m_axis.tlast, 0);
    chk("end_done", done, 1);
    chk("end_busy", busy, 1);
    exp_pkts = (exp_pkts + 1) & 16'hFFFF;
    chk("end_cnt", pkts_sent, exp_pkts);
    step();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_tvalid", m_axis.tvalid, 0);
  endtask

  initial begin
    m_axis.tready = 1'b0;
    #12;
    chk("rst_tvalid", m_axis.tvalid, 0);
    chk("rst_tlast", m_axis.tlast, 0);
    chk("rst_tdata", m_axis.tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", pkts_sent, 0);
    rst_n = 1'b0;
    step();

    run_packet(1, 2'd0, 32'hFFFF_FFFF, 0, -1, 0);
    run_packet(4, 2'd1, 32'hFFFF_FFFE, 2, -1, 0);
    run_packet(3, 2'd2, 32'hA5A5_A5A5, 0, -1, 1);
    run_packet(10, 2'd1, 32'h0000_0000, 0, 2, 0);
    run_packet(5, 2'd3, 32'h1234_5678, 1, 4, 0);
    run_packet(0, 2'd0, 32'hDEAD_BEEF, 0, -1, 0);

    for (int i = 0; i < 24; i++) begin
      run_packet($urandom_range(0, 12), 2'($urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 2),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 11) : -1,
                 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a packet after two words have transferred.
    start = 1'b1;
    pkt_len = LW'(5);
    mode = 2'd1;
    seed = 32'h0000_0100;
    m_axis.tready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_rst_tdata", m_axis.tdata, 32'h0000_0102);
    chk("pre_rst_tvalid", m_axis.tvalid, 1);
    #2;
    rst_n = 1'b1;
    #1;
    chk("mid_rst_tvalid", m_axis.tvalid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", pkts_sent, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_tlast", m_axis.tlast, 0);
    exp_pkts = 0;
    @(negedge clk);
    rst_n = 1'b0;
    step();
    chk("post_rst_tvalid", m_axis.tvalid, 0);
    run_packet(2, 2'd2, 32'h0F0F_0F0F, 0, -1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
